multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: one shared ALU, one shared instruction/data memory
// port and a 32x32 register file, sequenced by a twelve-state FSM.
module multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic [31:0] pc,
    input  logic [4:0]  dbg_ra,
    output logic [31:0] dbg_rd
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] dr;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] signimm;
    logic        funct_ok;
    logic        op_valid;
    logic        mem_go;

    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic [31:0] alu_y;
    logic        alu_zero;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign signimm = {{16{ir[15]}}, ir[15:0]};

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND)
                   || (funct == FN_OR)  || (funct == FN_SLT);

    assign op_valid = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ)
                   || (opcode == OP_ADDI) || (opcode == OP_J)
                   || ((opcode == OP_R) && funct_ok);

    // With waiting disabled every request completes on the first edge.
    assign mem_go = mem_req && (MEM_WAIT_EN ? mem_ready : 1'b1);

    assign rf_a   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rf_b   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign dbg_rd = (dbg_ra == 5'd0) ? 32'd0 : regs[dbg_ra];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        alu_a  = pc;
        alu_b  = 32'd4;
        alu_op = ALU_ADD;
        unique case (state)
            DECODE: alu_b = {signimm[29:0], 2'b00};
            MEMADR, ADDIEX: begin
                alu_a = a_reg;
                alu_b = signimm;
            end
            EXEC: begin
                alu_a = a_reg;
                alu_b = b_reg;
                unique case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            BRANCH: begin
                alu_a  = a_reg;
                alu_b  = b_reg;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        unique case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    assign alu_zero = (alu_y == 32'd0);

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out;
        unique case (state)
            MEMWB: begin
                rf_we = 1'b1;
                rf_wd = dr;
            end
            ALUWB: begin
                rf_we = 1'b1;
                rf_wa = rd;
            end
            ADDIWB: rf_we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mem_req   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        mem_we    = (state == MEMWR);
        mem_addr  = (state == FETCH) ? pc : alu_out;
        mem_wdata = b_reg;
        retire    = 1'b0;
        unique case (state)
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
            MEMWR:                              retire = mem_go;
            DECODE:                             retire = !op_valid;
            default: ;
        endcase
    end

    // NOTE: the register file is reset explicitly because all 32 entries must read 0
    // after reset; register 0 is never written so it stays 0 by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && (rf_wa != 5'd0)) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            dr      <= 32'd0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_go) begin
                        ir    <= mem_rdata;
                        pc    <= alu_y;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a_reg   <= rf_a;
                    b_reg   <= rf_b;
                    alu_out <= alu_y;
                    if (!op_valid) begin
                        state <= FETCH;
                    end else begin
                        unique case (opcode)
                            OP_LW, OP_SW: state <= MEMADR;
                            OP_R:         state <= EXEC;
                            OP_BEQ:       state <= BRANCH;
                            OP_ADDI:      state <= ADDIEX;
                            OP_J:         state <= JUMP;
                            default:      state <= FETCH;
                        endcase
                    end
                end
                MEMADR: begin
                    alu_out <= alu_y;
                    state   <= (opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    if (mem_go) begin
                        dr    <= mem_rdata;
                        state <= MEMWB;
                    end
                end
                MEMWR: begin
                    if (mem_go) state <= FETCH;
                end
                EXEC: begin
                    alu_out <= alu_y;
                    state   <= ALUWB;
                end
                BRANCH: begin
                    if (alu_zero) pc <= alu_out;
                    state <= FETCH;
                end
                ADDIEX: begin
                    alu_out <= alu_y;
                    state   <= ADDIWB;
                end
                JUMP: begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= FETCH;
                end
                MEMWB, ALUWB, ADDIWB: state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
